// File: rtl/flash_word_reader.sv
// Parallel-NOR flash word reader: power-up reset/init, then toggle req/ack word reads.
// Optional sequential prefetch is enabled by defining FLASH_WORD_PREFETCH_EN.
module flash_word_reader #(
    parameter int unsigned ADDR_W         = 23,
    parameter int unsigned BYTES_PER_WORD = 2,
    parameter int unsigned RESET_CYCLES   = 28,
    parameter int unsigned INIT_CYCLES    = 3,
    parameter int unsigned READ_CYCLES    = 6,
    parameter int unsigned BIG_ENDIAN     = 1
) (
    input  logic                        iclk,
    input  logic                        ireset,
    input  logic [7:0]                  iFL_DQ,
    output logic [ADDR_W-1:0]           oFL_ADDR,
    output logic                        oFL_RST_N,
    output logic                        oFL_CE_N,
    output logic                        oFL_OE_N,
    output logic                        oFL_WE_N,
    output logic                        oFL_WP_N,
    input  logic [ADDR_W-1:0]           ifl_addr,
    input  logic                        ifl_req,
    output logic                        ofl_ack,
    output logic [8*BYTES_PER_WORD-1:0] ofl_dout,
    output logic                        ofl_ready,
    output logic                        ofl_hit
);
    localparam int unsigned WORD_W  = 8 * BYTES_PER_WORD;
    localparam int unsigned MAX_RI  = (RESET_CYCLES > INIT_CYCLES) ? RESET_CYCLES : INIT_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_RI > READ_CYCLES) ? MAX_RI : READ_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned IDX_W   = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    typedef enum logic [2:0] {
        S_RESET, S_INIT, S_IDLE, S_ACCESS, S_WAIT, S_NEXT, S_HIT
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [IDX_W-1:0]    byte_idx, byte_idx_d;
    logic [ADDR_W-1:0]   lat_addr, lat_addr_d;
    logic [WORD_W-1:0]   asm_word, asm_d, asm_next;
    logic [ADDR_W-1:0]   fl_addr_d;
    logic                rst_n_d, ce_n_d, oe_n_d, ack_d, ready_d, hit_d;
    logic [WORD_W-1:0]   dout_d;
    logic                pending;
    logic                last_sample;

`ifdef FLASH_WORD_PREFETCH_EN
    logic                pf_active, pf_active_d;
    logic                pf_claim, pf_claim_d;
    logic                pf_valid, pf_valid_d;
    logic [ADDR_W-1:0]   pf_addr, pf_addr_d;
    logic [WORD_W-1:0]   pf_data, pf_data_d;
    logic                in_flight, pf_match, claimed;
`endif

    assign oFL_WE_N = 1'b1;
    assign oFL_WP_N = 1'b1;

    // Next-state and next-register computation
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        byte_idx_d  = byte_idx;
        lat_addr_d  = lat_addr;
        asm_d       = asm_word;
        fl_addr_d   = oFL_ADDR;
        rst_n_d     = oFL_RST_N;
        ce_n_d      = oFL_CE_N;
        oe_n_d      = oFL_OE_N;
        ack_d       = ofl_ack;
        dout_d      = ofl_dout;
        ready_d     = ofl_ready;
        hit_d       = 1'b0;
        pending     = (ifl_req != ofl_ack);
        last_sample = (cnt == CNT_W'(READ_CYCLES - 1)) &&
                      (byte_idx == IDX_W'(BYTES_PER_WORD - 1));
        asm_next    = (BIG_ENDIAN != 0)
                    ? ((asm_word << 8) | WORD_W'(iFL_DQ))
                    : ((asm_word >> 8) | (WORD_W'(iFL_DQ) << (WORD_W - 8)));
`ifdef FLASH_WORD_PREFETCH_EN
        pf_active_d = pf_active;
        pf_valid_d  = pf_valid;
        pf_addr_d   = pf_addr;
        pf_data_d   = pf_data;
        in_flight   = (state == S_ACCESS) || (state == S_WAIT) || (state == S_NEXT);
        pf_match    = pending && pf_active && (ifl_addr == lat_addr);
        claimed     = pf_claim || pf_match;
        pf_claim_d  = pf_claim || (in_flight && pf_match);
`endif

        // Requests seen before init completes are acknowledged and dropped
        if (!ofl_ready) begin
            ack_d = ifl_req;
        end

        case (state)
            S_RESET: begin
                rst_n_d = 1'b0;
                ce_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
                    cnt_d   = '0;
                    rst_n_d = 1'b1;
                    state_d = S_INIT;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_INIT: begin
                if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_IDLE: begin
`ifdef FLASH_WORD_PREFETCH_EN
                if (pending) begin
                    if (pf_valid && (ifl_addr == pf_addr)) begin
                        state_d = S_HIT;
                    end else begin
                        lat_addr_d  = ifl_addr;
                        pf_valid_d  = 1'b0;
                        pf_active_d = 1'b0;
                        state_d     = S_ACCESS;
                    end
                end
`else
                ce_n_d = 1'b1;
                oe_n_d = 1'b1;
                if (pending) begin
                    lat_addr_d = ifl_addr;
                    state_d    = S_ACCESS;
                end
`endif
            end
            S_ACCESS: begin
                fl_addr_d  = lat_addr;
                ce_n_d     = 1'b0;
                oe_n_d     = 1'b0;
                cnt_d      = '0;
                byte_idx_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == CNT_W'(READ_CYCLES - 1)) begin
                    asm_d = asm_next;
                    cnt_d = '0;
                    if (last_sample) begin
`ifdef FLASH_WORD_PREFETCH_EN
                        if (pf_active && !claimed) begin
                            pf_valid_d  = 1'b1;
                            pf_data_d   = asm_next;
                            pf_addr_d   = lat_addr;
                            pf_active_d = 1'b0;
                            state_d     = S_IDLE;
                        end else begin
                            dout_d      = asm_next;
                            ack_d       = ifl_req;
                            hit_d       = claimed;
                            pf_claim_d  = 1'b0;
                            pf_active_d = 1'b1;
                            lat_addr_d  = lat_addr + ADDR_W'(BYTES_PER_WORD);
                            state_d     = S_ACCESS;
                        end
`else
                        dout_d  = asm_next;
                        ack_d   = ifl_req;
                        ce_n_d  = 1'b1;
                        oe_n_d  = 1'b1;
                        state_d = S_IDLE;
`endif
                    end else begin
                        byte_idx_d = byte_idx + IDX_W'(1);
                        state_d    = S_NEXT;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_NEXT: begin
                fl_addr_d = oFL_ADDR + ADDR_W'(1);
                state_d   = S_WAIT;
            end
`ifdef FLASH_WORD_PREFETCH_EN
            S_HIT: begin
                dout_d      = pf_data;
                ack_d       = ifl_req;
                hit_d       = 1'b1;
                pf_valid_d  = 1'b0;
                pf_claim_d  = 1'b0;
                pf_active_d = 1'b1;
                lat_addr_d  = pf_addr + ADDR_W'(BYTES_PER_WORD);
                state_d     = S_ACCESS;
            end
`endif
            default: begin
                state_d = S_RESET;
            end
        endcase

`ifdef FLASH_WORD_PREFETCH_EN
        // A request for a different word aborts the in-flight prefetch
        if (in_flight && pf_active && !pf_claim && pending && !pf_match) begin
            lat_addr_d  = ifl_addr;
            pf_active_d = 1'b0;
            pf_claim_d  = 1'b0;
            pf_valid_d  = 1'b0;
            state_d     = S_ACCESS;
        end
`endif
    end

    // FSM state register
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state <= S_RESET;
        end else begin
            state <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            cnt       <= '0;
            byte_idx  <= '0;
            lat_addr  <= '0;
            asm_word  <= '0;
            oFL_ADDR  <= '0;
            oFL_RST_N <= 1'b0;
            oFL_CE_N  <= 1'b1;
            oFL_OE_N  <= 1'b1;
            ofl_ack   <= 1'b0;
            ofl_dout  <= '0;
            ofl_ready <= 1'b0;
            ofl_hit   <= 1'b0;
`ifdef FLASH_WORD_PREFETCH_EN
            pf_active <= 1'b0;
            pf_claim  <= 1'b0;
            pf_valid  <= 1'b0;
            pf_addr   <= '0;
            pf_data   <= '0;
`endif
        end else begin
            cnt       <= cnt_d;
            byte_idx  <= byte_idx_d;
            lat_addr  <= lat_addr_d;
            asm_word  <= asm_d;
            oFL_ADDR  <= fl_addr_d;
            oFL_RST_N <= rst_n_d;
            oFL_CE_N  <= ce_n_d;
            oFL_OE_N  <= oe_n_d;
            ofl_ack   <= ack_d;
            ofl_dout  <= dout_d;
            ofl_ready <= ready_d;
            ofl_hit   <= hit_d;
`ifdef FLASH_WORD_PREFETCH_EN
            pf_active <= pf_active_d;
            pf_claim  <= pf_claim_d;
            pf_valid  <= pf_valid_d;
            pf_addr   <= pf_addr_d;
            pf_data   <= pf_data_d;
`endif
        end
    end

endmodule

// File: doc/flash_word_reader.md
Name: flash_word_reader

Overview:
- Parametrised parallel-NOR flash read controller for the DE2-115 board.
- Performs the power-up reset/init sequence, then services word reads over a toggle req/ack handshake.
- Assembles BYTES_PER_WORD sequential byte reads from the 8-bit flash bus into one word.
- Sits between the board flash pins and ROM-fetch clients; adds configurable timing, word width and optional sequential prefetch.

Parameters:
- ADDR_W, 23: flash byte-address width.
- BYTES_PER_WORD, 2: bytes per returned word (1..4); output width is 8*BYTES_PER_WORD.
- RESET_CYCLES, 28: oFL_RST_N low time in iclk cycles (>=1).
- INIT_CYCLES, 3: post-reset recovery time before first access (>=1).
- READ_CYCLES, 6: address-to-data access time per byte (>=1).
- BIG_ENDIAN, 1: 1 = first byte read lands in the word MSB; 0 = first byte lands in the LSB.

Ports:
- iclk  in  1  clock (54 MHz nominal).
- ireset  in  1  reset; asynchronous, active-high.
- iFL_DQ  in  8  flash data bus.
- oFL_ADDR  out  ADDR_W  flash byte address.
- oFL_RST_N  out  1  flash reset, active-low.
- oFL_CE_N  out  1  chip enable, active-low.
- oFL_OE_N  out  1  output enable, active-low.
- oFL_WE_N  out  1  constant 1.
- oFL_WP_N  out  1  constant 1.
- ifl_addr  in  ADDR_W  requested byte address of word.
- ifl_req  in  1  toggle request.
- ofl_ack  out  1  toggle acknowledge.
- ofl_dout  out  8*BYTES_PER_WORD  read word.
- ofl_ready  out  1  init complete.
- ofl_hit  out  1  1-cycle pulse: request served from prefetch buffer.

Behaviour:
- Reset (asynchronous, any state):
  - Enter RESET; the full reset/init sequence reruns, and any in-flight or prefetch read is discarded.
  - Output values: oFL_RST_N=0, oFL_CE_N=1, oFL_OE_N=1, oFL_ADDR=0, ofl_dout=0, ofl_ack=0, ofl_ready=0, ofl_hit=0.
- RESET: hold RESET_CYCLES cycles with oFL_RST_N=0, then go to INIT.
- INIT: oFL_RST_N=1; hold INIT_CYCLES cycles, then go to IDLE and set ofl_ready=1.
- Requests before ready: while ofl_ready=0, ofl_ack<=ifl_req every cycle; those requests are dropped and never serviced.
- IDLE:
  - oFL_CE_N=oFL_OE_N=1.
  - A request is pending when ifl_req!=ofl_ack. On the detect edge (E0), latch ifl_addr and go to ACCESS.
- ACCESS (first byte):
  - On edge E0+1, oFL_ADDR<=latched addr and CE_N/OE_N<=0.
  - Wait READ_CYCLES edges; iFL_DQ is sampled on the last of these edges.
- NEXT (remaining bytes): one edge increments oFL_ADDR by 1, then wait READ_CYCLES edges and sample; repeat for the remaining BYTES_PER_WORD-1 bytes.
- Completion:
  - On the final sample edge, ofl_dout<=assembled word, ofl_ack<=ifl_req, and the state returns to IDLE.
  - Total latency is BYTES_PER_WORD*(READ_CYCLES+1) edges after E0; 14 at the defaults.
- Address arithmetic: modulo 2^ADDR_W. A word starting at the top address wraps its later bytes to 0.
- Client rules:
  - Hold ifl_addr stable from the toggle until the detect edge.
  - Do not toggle ifl_req again until ofl_ack matches. An extra toggle while busy is not tracked.
- ofl_dout changes only on completion edges and holds its value otherwise.

Optional Feature:
- Macro: FLASH_WORD_PREFETCH_EN.
- When defined:
  - After every completion, the block immediately reads the next word (addr+BYTES_PER_WORD, wrapping) into a prefetch buffer, keeping CE_N/OE_N low.
  - Pending request matches a valid buffer: ofl_dout<=buffer, ofl_ack toggles and ofl_hit pulses on edge E0+1, and the next prefetch starts.
  - Request matches the in-flight prefetch address: ack on that prefetch's completion edge, with ofl_hit=1.
  - Mismatch: the prefetch is aborted and a normal read starts at edge E0+1.
  - Reset invalidates the buffer.
- When undefined: no prefetch, ofl_hit is tied to 0, and CE_N/OE_N are high in IDLE.

Test Plan:
- Assert ireset mid-read at cycle 5 of ACCESS -> outputs return to reset values immediately; oFL_RST_N stays low 28 cycles, ofl_ready rises 31 cycles after release.
- Defaults; flash bytes 0x100=0xAB, 0x101=0xCD; toggle req with addr 0x100 -> ack toggles 14 cycles after detect, ofl_dout=0xABCD; with BIG_ENDIAN=0 -> 0xCDAB.
- BYTES_PER_WORD=4, READ_CYCLES=2, addr 0x7FFFFE -> bytes read at 0x7FFFFE, 0x7FFFFF, 0x0, 0x1; ack after 12 cycles.
- Toggle req while ofl_ready=0 -> ack follows req, no flash access; the first request after ready is serviced normally.
- FLASH_WORD_PREFETCH_EN: read 0x200, wait 20 cycles, read 0x202 -> ack on E0+1, ofl_hit pulses; then read 0x500 -> prefetch aborted, ack after 14 cycles, ofl_hit=0.
